// File: rtl/uart_pkg.sv
// Shared types and constants for the serial frame receiver.
package uart_pkg;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    BREAK  = 3'd0,
    IDLE   = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Parity scheme selectors.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Width of the data-bit counter; enough for up to 16 data bits.
  localparam int BCW = 5;

endpackage

// File: rtl/uart_frame_rx_if.sv
// Bundle of the serial line and the decoded-frame outputs.
//
// Strobe semantics: valid, parity_err and frame_err are single-cycle
// pulses with no back-pressure. A consumer must capture data and
// frame_count in the cycle a strobe is high; at most one strobe is high
// in any cycle. data holds its value between strobes.
interface uart_frame_rx_if #(
  parameter int DATA_BITS = 4,
  parameter int CNT_W     = 8
);
  import uart_pkg::*;

  logic                 signal;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic [CNT_W-1:0]     frame_count;
  state_t               state;       // debug view of the receiver FSM

  // Receiver side.
  modport master (
    input  signal,
    output data, valid, parity_err, frame_err, frame_count, state
  );

  // Line driver / register-block side.
  modport slave (
    output signal,
    input  data, valid, parity_err, frame_err, frame_count, state
  );
endinterface

// File: rtl/uart_parity_acc.sv
// Running XOR over data and parity bits, with the pass flag for the
// configured parity scheme.
module uart_parity_acc
  import uart_pkg::*;
#(
  parameter int PARITY_MODE = PAR_EVEN
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic ok
);

  logic acc;

  // Accumulate the XOR of every enabled bit; clear at each start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= 1'b0;
    end else if (clr) begin
      acc <= 1'b0;
    end else if (en) begin
      acc <= acc ^ bit_in;
    end
  end

  // Even scheme passes on an even count of ones, odd on an odd count.
  always_comb begin
    ok = 1'b1;
    case (PARITY_MODE)
      PAR_EVEN: ok = ~acc;
      PAR_ODD:  ok = acc;
      default:  ok = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Serial frame receiver: one bit per clock, configurable data width,
// parity scheme and stop-bit count, with a good-frame counter.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 4,
  parameter int PARITY_MODE = PAR_EVEN,
  parameter int STOP_BITS   = 1,
  parameter int CNT_W       = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_frame_rx_if.master bus
);

  if (DATA_BITS < 1 || DATA_BITS > 16 ||
      PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_ODD ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
    $error("uart_frame_rx: illegal DATA_BITS/PARITY_MODE/STOP_BITS");
  end

  state_t               state;
  logic [BCW-1:0]       bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic [CNT_W-1:0]     frame_count_q;

  logic acc_clr;
  logic acc_en;
  logic par_ok;

  // A start bit is accepted both from IDLE and directly from DONE.
  assign acc_clr = !bus.signal && (state == IDLE || state == DONE);
  assign acc_en  = (state == DATA) || (state == PARITY);

  uart_parity_acc #(
    .PARITY_MODE(PARITY_MODE)
  ) u_parity_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (acc_clr),
    .en    (acc_en),
    .bit_in(bus.signal),
    .ok    (par_ok)
  );

  // Frame FSM with registered strobes, captured word and good-frame count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= BREAK;
      bit_cnt       <= '0;
      stop_cnt      <= 1'b0;
      shreg         <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state)
        BREAK: begin
          if (bus.signal) state <= IDLE;
        end
        IDLE: begin
          if (!bus.signal) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          for (int i = 0; i < DATA_BITS; i++) begin
            if (bit_cnt == BCW'(i)) shreg[i] <= bus.signal;
          end
          if (bit_cnt == BCW'(DATA_BITS - 1)) begin
            state    <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            stop_cnt <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
        PARITY: begin
          state    <= STOP;
          stop_cnt <= 1'b0;
        end
        STOP: begin
          if (!bus.signal) begin
            state       <= BREAK;
            frame_err_q <= 1'b1;
          end else if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state  <= DONE;
            data_q <= shreg;
          end else begin
            stop_cnt <= 1'b1;
          end
        end
        DONE: begin
          valid_q      <= par_ok;
          parity_err_q <= !par_ok;
          if (par_ok) frame_count_q <= frame_count_q + CNT_W'(1);
          if (!bus.signal) begin
            state   <= DATA;
            bit_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= BREAK;
      endcase
    end
  end

  assign bus.data        = data_q;
  assign bus.valid       = valid_q;
  assign bus.parity_err  = parity_err_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.frame_count = frame_count_q;
  assign bus.state       = state;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: three configurations side by side, frames
// driven from a frame-level model, strobes checked by a monitor.
module tb_uart_frame_rx;
  import uart_pkg::*;

  localparam int EW = 59; // {kind[3], data[16], count[8], cycle[32]}

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cyc = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-instance configuration: A = defaults, B = 8/odd/2, C = 4/none/1 with 2-bit count
  int dbits[3] = '{4, 8, 4};
  int pmode[3] = '{1, 2, 0};
  int sbits[3] = '{1, 2, 1};
  int cntw[3]  = '{8, 8, 2};

  // Frame-level model state
  int          count[3];
  logic [15:0] last_data[3];

  logic [EW-1:0] exp_qa[$];
  logic [EW-1:0] exp_qb[$];
  logic [EW-1:0] exp_qc[$];

  uart_frame_rx_if #(.DATA_BITS(4), .CNT_W(8)) bus_a ();
  uart_frame_rx_if #(.DATA_BITS(8), .CNT_W(8)) bus_b ();
  uart_frame_rx_if #(.DATA_BITS(4), .CNT_W(2)) bus_c ();

  uart_frame_rx #(.DATA_BITS(4), .PARITY_MODE(1), .STOP_BITS(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.master));
  uart_frame_rx #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.master));
  uart_frame_rx #(.DATA_BITS(4), .PARITY_MODE(0), .STOP_BITS(1), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c.master));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Cycle index, advanced on every rising edge
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h, required 0x%0h (cycle %0d)",
               name, inst, act, exp, cyc);
    end
  endtask

  task automatic get_out(input int inst, output logic v, output logic pe, output logic fe,
                         output logic [15:0] d, output logic [7:0] cn, output logic [2:0] st);
    case (inst)
      0: begin v = bus_a.valid; pe = bus_a.parity_err; fe = bus_a.frame_err;
               d = 16'(bus_a.data); cn = 8'(bus_a.frame_count); st = bus_a.state; end
      1: begin v = bus_b.valid; pe = bus_b.parity_err; fe = bus_b.frame_err;
               d = 16'(bus_b.data); cn = 8'(bus_b.frame_count); st = bus_b.state; end
      default: begin v = bus_c.valid; pe = bus_c.parity_err; fe = bus_c.frame_err;
               d = 16'(bus_c.data); cn = 8'(bus_c.frame_count); st = bus_c.state; end
    endcase
  endtask

  task automatic set_line(input int inst, input logic b);
    case (inst)
      0: bus_a.signal = b;
      1: bus_b.signal = b;
      default: bus_c.signal = b;
    endcase
  endtask

  task automatic push_exp(input int inst, input logic [EW-1:0] e);
    case (inst)
      0: exp_qa.push_back(e);
      1: exp_qb.push_back(e);
      default: exp_qc.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int inst, output bit got, output logic [EW-1:0] e);
    got = 1'b0;
    e = '0;
    case (inst)
      0: if (exp_qa.size() > 0) begin e = exp_qa.pop_front(); got = 1'b1; end
      1: if (exp_qb.size() > 0) begin e = exp_qb.pop_front(); got = 1'b1; end
      default: if (exp_qc.size() > 0) begin e = exp_qc.pop_front(); got = 1'b1; end
    endcase
  endtask

  function automatic int q_size(input int inst);
    case (inst)
      0: return exp_qa.size();
      1: return exp_qb.size();
      default: return exp_qc.size();
    endcase
  endfunction

  task automatic check_zero(input int inst, input string tag);
    logic v, pe, fe; logic [15:0] d; logic [7:0] cn; logic [2:0] st;
    get_out(inst, v, pe, fe, d, cn, st);
    chk({tag, "_valid"}, inst, 32'(v), 32'd0);
    chk({tag, "_parity_err"}, inst, 32'(pe), 32'd0);
    chk({tag, "_frame_err"}, inst, 32'(fe), 32'd0);
    chk({tag, "_data"}, inst, 32'(d), 32'd0);
    chk({tag, "_frame_count"}, inst, 32'(cn), 32'd0);
    chk({tag, "_state"}, inst, 32'(st), 32'(BREAK));
  endtask

  // ---------------- driver ----------------
  // One bit per cycle, changed on the falling edge, sampled on the next rising edge
  task automatic drive_bit(input int inst, input logic b, output logic [31:0] c);
    @(negedge clk);
    set_line(inst, b);
    c = cyc;
  endtask

  task automatic idle(input int inst, input int n);
    logic [31:0] c;
    for (int j = 0; j < n; j++) drive_bit(inst, 1'b1, c);
  endtask

  // Sends one frame and records the expected strobe. stop_fail selects
  // which stop bit is driven 0 (-1: none). junk0 zero cycles follow a
  // framing error before the line returns high for gap+1 cycles.
  task automatic send_frame(input int inst, input logic [15:0] word, input bit bad_par,
                            input int stop_fail, input int junk0, input int gap);
    logic [31:0] c;
    logic [15:0] mask, w;
    logic par;
    bit ok;
    int ones;
    mask = 16'((32'd1 << dbits[inst]) - 32'd1);
    w = word & mask;
    drive_bit(inst, 1'b0, c);
    for (int i = 0; i < dbits[inst]; i++) drive_bit(inst, w[i], c);
    ones = $countones(w);
    if (pmode[inst] != 0) begin
      par = (pmode[inst] == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
      if (bad_par) par = ~par;
      drive_bit(inst, par, c);
      ones += int'(par);
    end
    ok = (pmode[inst] == 0) || (pmode[inst] == 1 ? (ones % 2 == 0) : (ones % 2 == 1));
    for (int s = 0; s < sbits[inst]; s++) begin
      if (s == stop_fail) begin
        drive_bit(inst, 1'b0, c);
        push_exp(inst, {3'b001, last_data[inst], 8'(count[inst]), c + 32'd1});
        for (int j = 0; j < junk0; j++) drive_bit(inst, 1'b0, c);
        idle(inst, gap + 1);
        return;
      end
      drive_bit(inst, 1'b1, c);
    end
    last_data[inst] = w;
    if (ok) begin
      count[inst] = (count[inst] + 1) % (1 << cntw[inst]);
      push_exp(inst, {3'b100, w, 8'(count[inst]), c + 32'd2});
    end else begin
      push_exp(inst, {3'b010, w, 8'(count[inst]), c + 32'd2});
    end
    idle(inst, gap);
  endtask

  task automatic send_random(input int inst, input int n);
    int sf;
    for (int k = 0; k < n; k++) begin
      sf = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, sbits[inst] - 1)) : -1;
      send_frame(inst, 16'($urandom), ($urandom_range(0, 3) == 0), sf,
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check_out(input int inst);
    logic v, pe, fe; logic [15:0] d; logic [7:0] cn; logic [2:0] st;
    logic [EW-1:0] e;
    bit got;
    get_out(inst, v, pe, fe, d, cn, st);
    if (!(v || pe || fe)) return;
    pop_exp(inst, got, e);
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL unexpected_strobe dut%0d: got valid/parity_err/frame_err=%b%b%b at cycle %0d, required none",
               inst, v, pe, fe, cyc);
      return;
    end
    chk("strobe_kind", inst, 32'({v, pe, fe}), 32'(e[58:56]));
    chk("data", inst, 32'(d), 32'(e[55:40]));
    chk("frame_count", inst, 32'(cn), 32'(e[39:32]));
    chk("strobe_cycle", inst, cyc, e[31:0]);
  endtask

  // Compare every strobe against the oldest expected frame outcome
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) check_out(i);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] c;
    logic v, pe, fe; logic [15:0] d; logic [7:0] cn; logic [2:0] st;
    for (int i = 0; i < 3; i++) begin
      count[i] = 0;
      last_data[i] = '0;
    end
    bus_a.signal = 1'b1;
    bus_b.signal = 1'b1;
    bus_c.signal = 1'b1;

    #12;
    for (int i = 0; i < 3; i++) check_zero(i, "reset");
    @(negedge clk);
    reset = 1'b1;

    // A: directed good frame, parity error, framing error with ignored zeros
    idle(0, 3);
    send_frame(0, 16'hD, 1'b0, -1, 0, 2);
    send_frame(0, 16'hD, 1'b1, -1, 0, 2);
    send_frame(0, 16'h6, 1'b0, 0, 3, 1);
    send_frame(0, 16'h9, 1'b0, -1, 0, 0);
    send_random(0, 20);
    idle(0, 4);

    // B: back-to-back frames, second start bit sampled in DONE, then bad second stop bit
    idle(1, 2);
    send_frame(1, 16'hA5, 1'b0, -1, 0, 0);
    send_frame(1, 16'h3C, 1'b0, -1, 0, 2);
    send_frame(1, 16'h5A, 1'b0, 1, 0, 1);
    send_frame(1, 16'h81, 1'b1, -1, 0, 1);
    send_random(1, 15);
    idle(1, 4);

    // C: no parity bit, 2-bit counter wraps after four good frames
    idle(2, 2);
    for (int k = 0; k < 5; k++)
      send_frame(2, 16'($urandom), 1'b0, -1, 0, int'($urandom_range(0, 2)));
    send_random(2, 12);
    idle(2, 4);

    // Asynchronous reset in the middle of a frame on A
    idle(0, 2);
    drive_bit(0, 1'b0, c);
    drive_bit(0, 1'b1, c);
    drive_bit(0, 1'b0, c);
    #7;
    get_out(0, v, pe, fe, d, cn, st);
    chk("pre_reset_state", 0, 32'(st), 32'(DATA));
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check_zero(i, "async_reset");
    exp_qa.delete();
    exp_qb.delete();
    exp_qc.delete();
    for (int i = 0; i < 3; i++) begin
      count[i] = 0;
      last_data[i] = '0;
    end
    bus_a.signal = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    idle(0, 1);
    send_frame(0, 16'hB, 1'b0, -1, 0, 2);
    send_frame(1, 16'hC3, 1'b0, -1, 0, 2);
    send_frame(2, 16'h5, 1'b0, -1, 0, 2);
    idle(0, 6);

    for (int i = 0; i < 3; i++) chk("pending_expected", i, 32'(q_size(i)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Parametrised successor to the fixed 4-bit even-parity UART frame checker.
- Receives one serial line sampled once per clk, with one bit per cycle and no oversampling.
- Frame format is configurable: data width, parity mode (none/even/odd) and 1 or 2 stop bits.
- Outputs: the captured data word, single-cycle valid / parity_err / frame_err strobes, and a count of good frames, all for the downstream register block.

Parameters:
- DATA_BITS, 4, data bits per frame; legal range 1..16; sent LSB first.
- PARITY_MODE, 1, parity scheme: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- CNT_W, 8, width of the good-frame counter.

Ports:
- clk, input, 1, system clock; all sampling on the rising edge.
- reset, input, 1, asynchronous, active-low reset (asserted when 0).
- signal, input, 1, serial line; idle level 1, sampled every posedge.
- data, output, DATA_BITS, last received data word.
- valid, output, 1, one-cycle strobe: frame complete and parity correct.
- parity_err, output, 1, one-cycle strobe: frame complete and parity wrong.
- frame_err, output, 1, one-cycle strobe: stop bit sampled as 0.
- frame_count, output, CNT_W, number of valid frames, modulo 2^CNT_W.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = BREAK; bit_cnt, stop_cnt, acc and the shift register all 0.
  - data = 0, frame_count = 0, valid = parity_err = frame_err = 0.
  - Reset asserted mid-frame aborts the frame immediately; no strobe is produced.
- States: BREAK, IDLE, DATA, PARITY, STOP, DONE. Each posedge samples signal exactly once.
  - BREAK: signal = 1 -> IDLE; otherwise stay.
  - IDLE: signal = 0 (start bit) -> DATA, with bit_cnt = 0 and acc = 0; otherwise stay.
  - DATA:
    - Shift-register bit[bit_cnt] <= signal; acc <= acc ^ signal.
    - If bit_cnt == DATA_BITS-1: go to PARITY (PARITY_MODE != 0) or to STOP (PARITY_MODE == 0), with stop_cnt = 0.
    - Otherwise bit_cnt++.
  - PARITY: acc <= acc ^ signal -> STOP, with stop_cnt = 0.
  - STOP:
    - signal = 0 -> BREAK, and frame_err is high for the following cycle.
    - signal = 1 and stop_cnt == STOP_BITS-1 -> DONE.
    - signal = 1 otherwise -> stop_cnt++, stay in STOP.
  - DONE (exactly one cycle):
    - signal = 0 is treated as the next start bit -> DATA, with bit_cnt = 0 and acc = 0. Back-to-back frames need no idle gap.
    - signal = 1 -> IDLE.
- Parity decision, evaluated on entry to DONE over the data bits plus the parity bit:
  - Even mode: parity is OK when acc == 0.
  - Odd mode: parity is OK when acc == 1.
  - Mode none: parity is always OK.
- Outputs are registered and asserted only while in DONE, or in the first BREAK cycle for frame_err:
  - valid = DONE and parity OK.
  - parity_err = DONE and parity not OK.
  - valid and parity_err are never high together.
- data is loaded from the shift register on entry to DONE, whether parity passes or fails. It holds its value until the next DONE; a framing error does not update it.
- frame_count increments on every valid strobe and wraps from 2^CNT_W-1 to 0.
- Latency: the last stop bit is sampled at edge k; the strobes and the new data are visible after edge k+1.
- Illegal parameters (DATA_BITS outside 1..16, PARITY_MODE = 3, STOP_BITS not 1 or 2) are rejected by an elaboration-time check.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (BREAK, IDLE, DATA, PARITY, STOP, DONE);
  - parity mode constants PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2.
- One sub-module is natural: uart_parity_acc, which does the running XOR with clear/enable and outputs the OK flag for the configured mode.
- Everything else stays in uart_frame_rx.

Test Plan:
- Defaults (4 data bits, even parity, 1 stop bit), after reset line high for 3 cycles, then bits 0 (start), 1,0,1,1 (data), 1 (parity), 1 (stop) -> valid for 1 cycle, data = 4'hD, frame_count = 1, parity_err = 0.
- Same frame with parity bit 0 -> parity_err for 1 cycle, valid = 0, data = 4'hD, frame_count unchanged.
- Stop bit driven 0 -> frame_err for 1 cycle, FSM returns to BREAK, data holds its previous value. The next start bit is ignored until the line has been 1 for at least one cycle.
- DATA_BITS = 8, PARITY_MODE = 2 (odd), STOP_BITS = 2, two back-to-back frames 0xA5 then 0x3C with correct parity, second start bit sampled in DONE -> two valid strobes exactly 12 cycles apart, data = 8'hA5 then 8'h3C. A stop sequence of 1,0 gives frame_err.
- PARITY_MODE = 0: a frame of 6 cycles (start, 4 data, stop) -> valid with no parity cycle. With CNT_W = 2, five good frames -> frame_count reads 1 after the counter wraps.
- reset pulsed low mid-DATA, asynchronously between edges -> all outputs 0 immediately; after release, a complete frame is received correctly.
